muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly upstream of the integer register file. It accepts one M-extension operation at a time from decode/issue, computes it over multiple cycles, and delivers a one-cycle writeback of data, destination index and write enable straight into the register file's write port. The issue stage stalls on `busy`.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (the design supports only 32).

Ports:
- clk  in  1  clock; everything updates on posedge.
- reset  in  1  one clock; reset is synchronous and active-low.
- start  in  1  issue strobe; sampled only when `busy`=0.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_value  in  WIDTH  operand A (dividend/multiplicand).
- rs2_value  in  WIDTH  operand B (divisor/multiplier).
- rd  in  5  destination register index.
- busy  out  1  unit occupied; new `start` is ignored while high.
- data  out  WIDTH  result; connects to the register-file write data.
- location_write  out  5  latched `rd`.
- write_enabled  out  1  one-cycle writeback pulse.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: if `start`=1, latch op, operands, rd. Go to MUL for op 0-3 and to DIV for op 4-7, or to DONE on a special case (see Configuration).
- MUL: radix-2 shift-add on operand magnitudes into a 2*WIDTH-bit product over WIDTH cycles.
  - Sign fix-up: MUL/MULH treat both operands as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - MUL returns the low WIDTH bits; the others return the high WIDTH bits.
- DIV: restoring division on magnitudes over WIDTH cycles.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - DIVU/REMU are unsigned.
- Architectural special cases, which are always the final result:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (0x80000000 / -1): DIV gives 0x80000000; REM gives 0.
- DONE: drive `data` and `location_write`, and pulse `write_enabled` for exactly one cycle. Next state is IDLE.
- rd=0: the full operation executes, `write_enabled` stays 0, and `busy` timing is unchanged.
- `busy`=1 in MUL, DIV and DONE; `busy`=0 in IDLE.

## Timing
- Reset values (reset=0 at a posedge):
  - state IDLE
  - busy=0, write_enabled=0, data=0, location_write=0
  - all internal registers 0
- Reset mid-operation aborts the operation with no writeback; `start` in the same cycle as reset is dropped.
- Iterative path: `start` accepted at edge T → busy=1 from T+1; DONE occupies cycle T+WIDTH+1; write_enabled=1 in that cycle only; busy=0 from T+WIDTH+2.
- Back-to-back: the earliest next `start` is accepted at the edge that ends IDLE, i.e. one idle cycle between operations.
- `data` and `location_write` hold their last values after DONE until the next DONE.
- Operand inputs are don't-care after acceptance.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: divide-by-zero and signed overflow are detected in IDLE and go straight to DONE. write_enabled is high in cycle T+1 (latency 1).
- Undefined: special cases run the full WIDTH-cycle DIV sequence; the architectural value is selected at DONE. Latency is identical to normal division.
- Results are bit-identical either way; only latency differs.

## Test plan
- Reset: reset=0 for 2 cycles with start=1 → busy, write_enabled, data and location_write are all 0; no writeback follows.
- MUL / MULH: rs1=0xFFFFFFFF, rs2=0x00000002, rd=5.
  - MUL → data=0xFFFFFFFE, location_write=5, pulse at T+33.
  - MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
- DIV / REM: rs1=-7 (0xFFFFFFF9), rs2=2 → DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1), DIVU=0x7FFFFFFC, REMU=1.
- Special cases: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REMU 42 / 0 → 42; DIVU 42 / 0 → 0xFFFFFFFF.
  - Pulse at T+1 with `MULDIV_EARLY_OUT_EN` defined, T+33 without.
- Busy and rd=0: start with rd=0 → no write_enabled pulse; a second start asserted while busy → ignored, only one result emitted.
- Reset mid-operation: reset at cycle 10 of a DIV → no pulse; a fresh MUL 3*4 afterwards → 12.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit with one-cycle writeback.
// Optional macro MULDIV_EARLY_OUT_EN: resolve div-by-zero/overflow in 1 cycle.
// Revision: 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1_value,
  input  logic [WIDTH-1:0] rs2_value,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic [4:0]       location_write,
  output logic             write_enabled
);

  localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit c_early_out = 1'b1;
`else
  localparam bit c_early_out = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [4:0]       r_rd, r_loc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, r_spec_val, r_data;
  logic             r_neg, r_spec, r_we;

  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_spec_val;
  logic             w_divzero, w_ovf, w_special, w_last;
  logic [WIDTH:0]   w_msum, w_dtrial;
  logic [2*WIDTH-1:0] w_mul_next, w_mul_res;
  logic [WIDTH-1:0] w_div_hi, w_div_lo, w_result;

  // Operand decode for the issue cycle
  always_comb begin
    w_a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    w_b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    w_a_neg    = w_a_signed && rs1_value[WIDTH-1];
    w_b_neg    = w_b_signed && rs2_value[WIDTH-1];
    w_a_mag    = w_a_neg ? -rs1_value : rs1_value;
    w_b_mag    = w_b_neg ? -rs2_value : rs2_value;
    w_divzero  = op[2] && (rs2_value == '0);
    w_ovf      = op[2] && !op[0] && (rs1_value == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_value == '1);
    w_special  = w_divzero || w_ovf;
    w_spec_val = '0;
    if (w_divzero)
      w_spec_val = op[1] ? rs1_value : '1;
    else if (w_ovf)
      w_spec_val = op[1] ? '0 : rs1_value;
  end

  // One shift-add / restoring-subtract step; result selected from the step output
  always_comb begin
    w_last     = (r_cnt == CW'(WIDTH-1));
    w_msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_msum, r_lo[WIDTH-1:1]};
    w_mul_res  = r_neg ? -w_mul_next : w_mul_next;
    w_dtrial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
    w_div_hi   = w_dtrial[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_dtrial[WIDTH-1:0];
    w_div_lo   = {r_lo[WIDTH-2:0], ~w_dtrial[WIDTH]};
    if (r_spec)
      w_result = r_spec_val;
    else if (r_state == S_MUL)
      w_result = (r_op == 3'd0) ? w_mul_res[WIDTH-1:0] : w_mul_res[2*WIDTH-1:WIDTH];
    else if (r_op[1])
      w_result = r_neg ? -w_div_hi : w_div_hi;
    else
      w_result = r_neg ? -w_div_lo : w_div_lo;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (c_early_out && w_special) w_next = S_DONE;
          else if (op[2])               w_next = S_DIV;
          else                          w_next = S_MUL;
        end
      end
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DIV:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_rd       <= '0;
      r_loc      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_spec_val <= '0;
      r_data     <= '0;
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op       <= op;
            r_rd       <= rd;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_spec     <= w_special;
            r_spec_val <= w_spec_val;
            // Remainder follows the dividend; everything else follows the sign product
            r_neg      <= (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            if (op[2]) begin
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
            if (c_early_out && w_special) begin
              r_data <= w_spec_val;
              r_loc  <= rd;
              r_we   <= (rd != 5'd0);
            end
          end
        end
        S_MUL, S_DIV: begin
          if (r_state == S_MUL) begin
            {r_hi, r_lo} <= w_mul_next;
          end else begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_data <= w_result;
            r_loc  <= r_rd;
            r_we   <= (r_rd != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign data           = r_data;
  assign location_write = r_loc;
  assign write_enabled  = r_we;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed vector table plus multi-cycle corner sequences.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SPEC = 1;
`else
  localparam int LAT_SPEC = 33;
`endif
  localparam int LAT_NORM = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_value = '0, rs2_value = '0;
  logic [4:0]  rd = '0;
  logic        busy, write_enabled;
  logic [31:0] data;
  logic [4:0]  location_write;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rd(rd),
    .busy(busy), .data(data), .location_write(location_write),
    .write_enabled(write_enabled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; leaves at a negedge with the unit idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input int lat,
                        input string name);
    int we_cyc, busy_cyc, pulses;
    logic [31:0] got;
    logic [4:0]  gl;
    start = 1'b1; op = o; rs1_value = a; rs2_value = b; rd = d;
    @(posedge clk); #1;
    start = 1'b0; rs1_value = $urandom; rs2_value = $urandom; rd = 5'($urandom);
    we_cyc = -1; busy_cyc = -1; pulses = 0; got = '0; gl = '0;
    for (int k = 1; k <= 40 && busy_cyc < 0; k++) begin
      @(negedge clk);
      if (write_enabled) begin
        pulses++;
        if (we_cyc < 0) begin we_cyc = k; got = data; gl = location_write; end
      end
      if (!busy) busy_cyc = k;
    end
    check({name, " pulses"}, 64'(pulses), (d != 5'd0) ? 64'd1 : 64'd0);
    if (d != 5'd0) begin
      check({name, " pulse_cycle"}, 64'(we_cyc), 64'(lat));
      check({name, " data"}, 64'(got), 64'(exp));
      check({name, " loc"}, 64'(gl), 64'(d));
      check({name, " data_hold"}, 64'(data), 64'(exp));
    end
    check({name, " busy_drop"}, 64'(busy_cyc), 64'(lat + 1));
  endtask

  initial begin
    int pulses, busy_seen;
    logic [31:0] got;
    logic [4:0]  gl;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'h00000001, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'h7FFFFFFC, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'h00000001, 1'b0};
    vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b1};
    vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1'b1};
    vecs[10] = '{3'd7, 32'd42,       32'h00000000, 5'd12, 32'd42,       1'b1};
    vecs[11] = '{3'd5, 32'd42,       32'h00000000, 5'd13, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{3'd4, 32'hFFFFFFF9, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1'b1};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd15, 32'hFFFFFFF9, 1'b1};
    vecs[14] = '{3'd0, 32'd3,        32'd4,        5'd31, 32'd12,       1'b0};
    vecs[15] = '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0};
    vecs[16] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0};
    vecs[17] = '{3'd4, 32'd100,      32'hFFFFFFF9, 5'd3,  32'hFFFFFFF2, 1'b0};
    vecs[18] = '{3'd6, 32'd100,      32'hFFFFFFF9, 5'd4,  32'd2,        1'b0};
    vecs[19] = '{3'd5, 32'd1000,     32'd10,       5'd20, 32'd100,      1'b0};

    // Reset held two cycles with start asserted
    reset = 1'b0; start = 1'b1; op = 3'd0; rs1_value = 32'd5; rs2_value = 32'd6; rd = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset we", 64'(write_enabled), 64'd0);
    check("reset data", 64'(data), 64'd0);
    check("reset loc", 64'(location_write), 64'd0);
    reset = 1'b1; start = 1'b0;
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (write_enabled) pulses++;
      if (busy) busy_seen++;
    end
    check("reset no_pulse", 64'(pulses), 64'd0);
    check("reset no_busy", 64'(busy_seen), 64'd0);

    // Vector table, issued back to back
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
             vecs[i].spec ? LAT_SPEC : LAT_NORM, $sformatf("vec%0d", i));

    // rd=0: full operation, no writeback
    run_op(3'd0, 32'd7, 32'd9, 5'd0, 32'd63, LAT_NORM, "rd0 mul");
    run_op(3'd5, 32'd42, 32'd0, 5'd0, 32'hFFFFFFFF, LAT_SPEC, "rd0 divu0");

    // Second start while busy is ignored
    start = 1'b1; op = 3'd0; rs1_value = 32'd3; rs2_value = 32'd4; rd = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_value = 32'd100; rs2_value = 32'd5; rd = 5'd10;
    repeat (5) @(negedge clk);
    start = 1'b0;
    pulses = 0; got = '0; gl = '0;
    repeat (80) begin
      @(negedge clk);
      if (write_enabled) begin pulses++; got = data; gl = location_write; end
    end
    check("busy_ign pulses", 64'(pulses), 64'd1);
    check("busy_ign data", 64'(got), 64'd12);
    check("busy_ign loc", 64'(gl), 64'd9);

    // Reset mid-division aborts without writeback
    start = 1'b1; op = 3'd5; rs1_value = 32'd1000; rs2_value = 32'd10; rd = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst loc", 64'(location_write), 64'd0);
    check("midrst data", 64'(data), 64'd0);
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (write_enabled) pulses++;
      if (busy) busy_seen++;
    end
    check("midrst no_pulse", 64'(pulses), 64'd0);
    check("midrst no_busy", 64'(busy_seen), 64'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, LAT_NORM, "post_rst mul");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
